// File: rtl/banked_sp_ram.sv
// Banked single-port RAM with per-bank idle-driven retention.
// Sleep FSMs are built only when BANKED_SP_RAM_SLEEP_EN is defined; otherwise every bank stays active.
module banked_sp_ram #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_BANKS    = 4,
    parameter int unsigned BANK_SIZE    = 8192,
    parameter int unsigned ADDR_WIDTH   = 15,
    parameter int unsigned SLEEP_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES  = 2
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic [NUM_BANKS-1:0]    bank_sleep_o
);

    localparam int unsigned BE_W   = DATA_WIDTH / 8;
    localparam int unsigned ROW_W  = $clog2(BANK_SIZE);
    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(NUM_BANKS * BANK_SIZE);

`ifdef BANKED_SP_RAM_SLEEP_EN
    localparam int unsigned IDLE_W = $clog2(SLEEP_CYCLES + 1);
    localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_SLEEP,
        ST_WAKE
    } state_e;
`endif

    logic                                  oor;
    logic [BANK_W-1:0]                     bank_idx;
    logic [ROW_W-1:0]                      row_idx;
    logic [NUM_BANKS-1:0]                  bank_active;
    logic [NUM_BANKS-1:0]                  bank_gnt;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  bank_rdata;

    assign oor      = {1'b0, addr_i} >= ADDR_LIMIT;
    assign row_idx  = addr_i[ROW_W-1:0];
    assign bank_idx = addr_i[ROW_W +: BANK_W];
    // Out-of-range requests never touch a bank, so they are accepted regardless of bank state.
    assign gnt_o    = req_i & (oor | bank_active[bank_idx]);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                  bank_hit;
        logic [DATA_WIDTH-1:0] mem [BANK_SIZE];
        logic [DATA_WIDTH-1:0] rd_q;

        assign bank_hit    = req_i & ~oor & (bank_idx == BANK_W'(b));
        assign bank_gnt[b] = bank_hit & bank_active[b];

        // Storage and its read register carry no reset: contents survive reset and retention.
        always_ff @(posedge clk_i) begin
            if (bank_gnt[b]) begin
                if (we_i) begin
                    for (int unsigned i = 0; i < BE_W; i++) begin
                        if (be_i[i]) begin
                            mem[row_idx][8*i +: 8] <= wdata_i[8*i +: 8];
                        end
                    end
                end else begin
                    rd_q <= mem[row_idx];
                end
            end
        end

        assign bank_rdata[b] = rd_q;

`ifdef BANKED_SP_RAM_SLEEP_EN
        state_e            state_q, state_d;
        logic [IDLE_W-1:0] idle_q, idle_d;
        logic [WAKE_W-1:0] wake_q, wake_d;

        always_comb begin
            state_d = state_q;
            idle_d  = idle_q;
            wake_d  = wake_q;
            case (state_q)
                ST_ACTIVE: begin
                    // A grant on the final idle cycle keeps the bank awake.
                    if (bank_gnt[b]) begin
                        idle_d = '0;
                    end else if (idle_q == IDLE_W'(SLEEP_CYCLES - 1)) begin
                        state_d = ST_SLEEP;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                ST_SLEEP: begin
                    if (bank_hit) begin
                        state_d = ST_WAKE;
                        wake_d  = '0;
                    end
                end
                ST_WAKE: begin
                    if (wake_q == WAKE_W'(WAKE_CYCLES - 1)) begin
                        state_d = ST_ACTIVE;
                        idle_d  = '0;
                    end else begin
                        wake_d = wake_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_ACTIVE;
                    idle_d  = '0;
                end
            endcase
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                state_q <= ST_ACTIVE;
                idle_q  <= '0;
                wake_q  <= '0;
            end else begin
                state_q <= state_d;
                idle_q  <= idle_d;
                wake_q  <= wake_d;
            end
        end

        assign bank_active[b]  = (state_q == ST_ACTIVE);
        assign bank_sleep_o[b] = (state_q == ST_SLEEP);
`else
        assign bank_active[b]  = 1'b1;
        assign bank_sleep_o[b] = 1'b0;
`endif
    end

    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic              zero_q, zero_d;
    logic [BANK_W-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    always_comb begin
        rvalid_d = gnt_o;
        err_d    = gnt_o & oor;
        zero_d   = gnt_o & (oor | we_i);
        sel_d    = gnt_o ? bank_idx : sel_q;
        hold_d   = rdata_o;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
            sel_q    <= '0;
            hold_q   <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
            sel_q    <= sel_d;
            hold_q   <= hold_d;
        end
    end

    // Bank select comes from the grant cycle; hold_q keeps the last response visible while idle.
    assign rdata_o  = rvalid_q ? (zero_q ? '0 : bank_rdata[sel_q]) : hold_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_banked_sp_ram.sv
// Self-checking bench for banked_sp_ram; sleep scenarios run when BANKED_SP_RAM_SLEEP_EN is defined.
module tb_banked_sp_ram;

    localparam int unsigned DW = 32;
    localparam int unsigned NB = 4;
    localparam int unsigned BS = 8192;
    localparam int unsigned AW = 16;
    localparam int unsigned LIMIT = NB * BS;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          req_i;
    logic          gnt_o;
    logic [AW-1:0] addr_i;
    logic          we_i;
    logic [3:0]    be_i;
    logic [DW-1:0] wdata_i;
    logic          rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          err_o;
    logic [NB-1:0] bank_sleep_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [int];

    banked_sp_ram #(
        .DATA_WIDTH  (DW),
        .NUM_BANKS   (NB),
        .BANK_SIZE   (BS),
        .ADDR_WIDTH  (AW),
        .SLEEP_CYCLES(16),
        .WAKE_CYCLES (2)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .bank_sleep_o(bank_sleep_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // One transfer: waits (bounded) for grant, returns the response one cycle after grant.
    task automatic access(input logic [AW-1:0] a, input logic w, input logic [3:0] be, input logic [31:0] d,
                          output logic granted, output int lat, output logic rv, output logic er,
                          output logic [31:0] rd);
        @(negedge clk_i);
        req_i = 1'b1; addr_i = a; we_i = w; be_i = be; wdata_i = d;
        lat = 0; granted = 1'b0;
        #1;
        while (!granted && lat < 12) begin
            if (gnt_o === 1'b1) granted = 1'b1;
            else begin
                @(negedge clk_i); #1; lat++;
            end
        end
        if (granted) begin
            @(posedge clk_i);
            @(negedge clk_i);
            req_i = 1'b0;
            #1;
            rv = rvalid_o; er = err_o; rd = rdata_o;
        end else begin
            req_i = 1'b0;
            rv = 1'b0; er = 1'b0; rd = '0;
        end
    endtask

    task automatic apply_reset();
        req_i = 1'b0;
        rstn_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        logic g, rv, er; int lat; logic [31:0] rd;
        #1;
        total++;
        if ({rvalid_o, err_o, rdata_o, bank_sleep_o} !== '0) begin
            bad++; $display("FAIL reset_state: got rv=%b er=%b rd=%h sl=%b want all zero", rvalid_o, err_o, rdata_o, bank_sleep_o);
        end
        @(negedge clk_i); rstn_i = 1'b1;
        access(16'h0010, 1'b1, 4'hF, 32'h5A5A5A5A, g, lat, rv, er, rd);
        access(16'h0010, 1'b0, 4'hF, 32'h0, g, lat, rv, er, rd);
        total++;
        if (rd !== 32'h5A5A5A5A) begin
            bad++; $display("FAIL reset_preload: got %h want 5a5a5a5a", rd);
        end
        @(negedge clk_i);
        req_i = 1'b1; addr_i = 16'h0010; we_i = 1'b0;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        total++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h5A5A5A5A) begin
            bad++; $display("FAIL reset_preresp: got rv=%b rd=%h want rv=1 rd=5a5a5a5a", rvalid_o, rdata_o);
        end
        rstn_i = 1'b0;
        #1;
        total++;
        if ({rvalid_o, err_o, rdata_o, bank_sleep_o} !== '0) begin
            bad++; $display("FAIL reset_midresp: got rv=%b er=%b rd=%h sl=%b want all zero", rvalid_o, err_o, rdata_o, bank_sleep_o);
        end
        @(negedge clk_i); rstn_i = 1'b1;
    endtask

    task automatic test_write_read();
        logic g, rv, er; int lat; logic [31:0] rd;
        apply_reset();
        access(16'h2005, 1'b1, 4'hF, 32'hDEADBEEF, g, lat, rv, er, rd);
        total++;
        if (!g || lat != 0 || rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
            bad++; $display("FAIL wr_resp: got g=%b lat=%0d rv=%b er=%b rd=%h want g=1 lat=0 rv=1 er=0 rd=0", g, lat, rv, er, rd);
        end
        access(16'h2005, 1'b0, 4'hF, 32'h0, g, lat, rv, er, rd);
        total++;
        if (!g || lat != 0 || rv !== 1'b1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_resp: got g=%b lat=%0d rv=%b er=%b rd=%h want g=1 lat=0 rv=1 er=0 rd=deadbeef", g, lat, rv, er, rd);
        end
        @(negedge clk_i); #1;
        total++;
        if (rvalid_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'hDEADBEEF) begin
            bad++; $display("FAIL idle_hold: got rv=%b er=%b rd=%h want rv=0 er=0 rd=deadbeef", rvalid_o, err_o, rdata_o);
        end
    endtask

    task automatic test_byte_enable();
        logic g, rv, er; int lat; logic [31:0] rd;
        apply_reset();
        access(16'h4123, 1'b1, 4'hF, 32'h11223344, g, lat, rv, er, rd);
        access(16'h4123, 1'b1, 4'h5, 32'hAABBCCDD, g, lat, rv, er, rd);
        access(16'h4123, 1'b0, 4'hF, 32'h0, g, lat, rv, er, rd);
        total++;
        if (rd !== 32'h11BB33DD) begin
            bad++; $display("FAIL be_5: got %h want 11bb33dd", rd);
        end
        access(16'h4123, 1'b1, 4'hA, 32'h99887766, g, lat, rv, er, rd);
        access(16'h4123, 1'b1, 4'h0, 32'hFFFFFFFF, g, lat, rv, er, rd);
        access(16'h4123, 1'b0, 4'hF, 32'h0, g, lat, rv, er, rd);
        total++;
        if (rd !== 32'h99BB77DD) begin
            bad++; $display("FAIL be_a_0: got %h want 99bb77dd", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic g, rv, er; int lat; logic [31:0] rd;
        apply_reset();
        access(16'h0001, 1'b1, 4'hF, 32'hA0A00001, g, lat, rv, er, rd);
        access(16'h6001, 1'b1, 4'hF, 32'hB3B36001, g, lat, rv, er, rd);
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 16'h0001; #1;
        total++;
        if (gnt_o !== 1'b1) begin bad++; $display("FAIL b2b_gnt0: got %b want 1", gnt_o); end
        @(negedge clk_i); addr_i = 16'h6001; #1;
        total++;
        if (gnt_o !== 1'b1 || rvalid_o !== 1'b1 || rdata_o !== 32'hA0A00001) begin
            bad++; $display("FAIL b2b_rsp0: got g=%b rv=%b rd=%h want 1 1 a0a00001", gnt_o, rvalid_o, rdata_o);
        end
        @(negedge clk_i); addr_i = 16'h0001; #1;
        total++;
        if (gnt_o !== 1'b1 || rvalid_o !== 1'b1 || rdata_o !== 32'hB3B36001) begin
            bad++; $display("FAIL b2b_rsp1: got g=%b rv=%b rd=%h want 1 1 b3b36001", gnt_o, rvalid_o, rdata_o);
        end
        @(negedge clk_i); req_i = 1'b0; addr_i = 16'h6001; #1;
        total++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'hA0A00001) begin
            bad++; $display("FAIL b2b_rsp2: got rv=%b rd=%h want 1 a0a00001", rvalid_o, rdata_o);
        end
    endtask

    task automatic test_out_of_range();
        logic g, rv, er; int lat; logic [31:0] rd;
        apply_reset();
        access(16'h7FFF, 1'b1, 4'hF, 32'h13572468, g, lat, rv, er, rd);
        access(16'h7FFF, 1'b0, 4'hF, 32'h0, g, lat, rv, er, rd);
        access(16'h8000, 1'b0, 4'hF, 32'h0, g, lat, rv, er, rd);
        total++;
        if (!g || lat != 0 || rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL oor_read: got g=%b lat=%0d rv=%b er=%b rd=%h want 1 0 1 1 0", g, lat, rv, er, rd);
        end
        access(16'hFFFF, 1'b1, 4'hF, 32'hFFFFFFFF, g, lat, rv, er, rd);
        total++;
        if (!g || lat != 0 || rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL oor_write: got g=%b lat=%0d rv=%b er=%b rd=%h want 1 0 1 1 0", g, lat, rv, er, rd);
        end
        access(16'h7FFF, 1'b0, 4'hF, 32'h0, g, lat, rv, er, rd);
        total++;
        if (er !== 1'b0 || rd !== 32'h13572468) begin
            bad++; $display("FAIL oor_alias: got er=%b rd=%h want er=0 rd=13572468", er, rd);
        end
    endtask

`ifdef BANKED_SP_RAM_SLEEP_EN
    task automatic test_sleep_wake();
        logic g, rv, er; int lat; logic [31:0] rd; int early;
        apply_reset();
        access(16'h2100, 1'b1, 4'hF, 32'hC0FFEE01, g, lat, rv, er, rd);
        early = 0;
        if (bank_sleep_o[1] !== 1'b0) early++;
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk_i); #1;
            if (bank_sleep_o[1] !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin bad++; $display("FAIL sleep_early: got %0d asleep cycles want 0", early); end
        @(negedge clk_i); #1;
        total++;
        if (bank_sleep_o[1] !== 1'b1) begin bad++; $display("FAIL sleep_enter: got %b want 1", bank_sleep_o[1]); end
        repeat (12) @(negedge clk_i);
        access(16'h2100, 1'b0, 4'hF, 32'h0, g, lat, rv, er, rd);
        total++;
        if (!g || lat != 3 || rv !== 1'b1 || er !== 1'b0 || rd !== 32'hC0FFEE01) begin
            bad++; $display("FAIL wake_read: got g=%b lat=%0d rv=%b er=%b rd=%h want 1 3 1 0 c0ffee01", g, lat, rv, er, rd);
        end
        total++;
        if (bank_sleep_o !== 4'b1101) begin
            bad++; $display("FAIL sleep_indep: got %b want 1101", bank_sleep_o);
        end
    endtask

    task automatic test_reset_in_wake();
        apply_reset();
        repeat (20) @(negedge clk_i);
        #1;
        total++;
        if (bank_sleep_o !== 4'hF) begin bad++; $display("FAIL all_asleep: got %b want 1111", bank_sleep_o); end
        @(negedge clk_i);
        req_i = 1'b1; addr_i = 16'h4000; we_i = 1'b0; be_i = 4'hF;
        @(negedge clk_i); #1;
        total++;
        if (bank_sleep_o[2] !== 1'b0 || gnt_o !== 1'b0) begin
            bad++; $display("FAIL in_wake: got sl=%b g=%b want 0 0", bank_sleep_o[2], gnt_o);
        end
        rstn_i = 1'b0;
        #1;
        total++;
        if (bank_sleep_o !== 4'h0 || rvalid_o !== 1'b0) begin
            bad++; $display("FAIL wake_reset: got sl=%b rv=%b want 0000 0", bank_sleep_o, rvalid_o);
        end
        @(negedge clk_i); rstn_i = 1'b1; #1;
        total++;
        if (gnt_o !== 1'b1) begin bad++; $display("FAIL post_reset_gnt: got %b want 1", gnt_o); end
        @(posedge clk_i); @(negedge clk_i); req_i = 1'b0; #1;
        total++;
        if (rvalid_o !== 1'b1 || err_o !== 1'b0) begin
            bad++; $display("FAIL post_reset_rsp: got rv=%b er=%b want 1 0", rvalid_o, err_o);
        end
    endtask
`else
    task automatic test_no_sleep();
        logic g, rv, er; int lat; logic [31:0] rd;
        apply_reset();
        repeat (40) @(negedge clk_i);
        #1;
        total++;
        if (bank_sleep_o !== 4'h0) begin bad++; $display("FAIL no_sleep: got %b want 0000", bank_sleep_o); end
        access(16'h2005, 1'b0, 4'hF, 32'h0, g, lat, rv, er, rd);
        total++;
        if (!g || lat != 0 || rd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL no_sleep_rd: got g=%b lat=%0d rd=%h want 1 0 deadbeef", g, lat, rd);
        end
    endtask
`endif

    task automatic test_random();
        logic g, rv, er; int lat; logic [31:0] rd;
        logic [AW-1:0] pool [24];
        logic [AW-1:0] a; logic w; logic [3:0] be; logic [31:0] d;
        logic [33:0] exp_rsp; bit is_oor; int max_lat;
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            pool[i] = AW'($urandom_range(0, LIMIT - 1));
            d = $urandom;
            access(pool[i], 1'b1, 4'hF, d, g, lat, rv, er, rd);
            model[int'(pool[i])] = d;
        end
        for (int n = 0; n < 250; n++) begin
            is_oor = ($urandom_range(0, 9) == 0);
            a  = is_oor ? AW'($urandom_range(LIMIT, 65535)) : pool[$urandom_range(0, 23)];
            w  = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            d  = $urandom;
            if (is_oor) exp_rsp = {1'b1, 1'b1, 32'h0};
            else if (w) exp_rsp = {1'b1, 1'b0, 32'h0};
            else exp_rsp = {1'b1, 1'b0, model[int'(a)]};
`ifdef BANKED_SP_RAM_SLEEP_EN
            max_lat = is_oor ? 0 : 3;
`else
            max_lat = 0;
`endif
            access(a, w, be, d, g, lat, rv, er, rd);
            if (!is_oor && w) model[int'(a)] = merge(model[int'(a)], d, be);
            total++;
            if (!g || lat > max_lat) begin
                bad++; $display("FAIL rand_gnt: addr=%h got g=%b lat=%0d want g=1 lat<=%0d", a, g, lat, max_lat);
            end
            total++;
            if ({rv, er, rd} !== exp_rsp) begin
                bad++; $display("FAIL rand_rsp: addr=%h we=%b got %h want %h", a, w, {rv, er, rd}, exp_rsp);
            end
            if ($urandom_range(0, 19) == 0) repeat (20) @(negedge clk_i);
        end
    endtask

    initial begin
        rstn_i = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
`ifdef BANKED_SP_RAM_SLEEP_EN
        test_sleep_wake();
        test_reset_in_wake();
`else
        test_no_sleep();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/banked_sp_ram.md
BANKED_SP_RAM -- requirements
Module: banked_sp_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits, multiple of 8.
REQ-002 SHALL have parameter NUM_BANKS, default 4, bank count, power of two, >= 2.
REQ-003 SHALL have parameter BANK_SIZE, default 8192, words per bank, power of two.
REQ-004 SHALL have parameter ADDR_WIDTH, default 15, word-address width, >= log2(NUM_BANKS*BANK_SIZE).
REQ-005 SHALL have parameter SLEEP_CYCLES, default 16, idle cycles before a bank enters retention, >= 1.
REQ-006 SHALL have parameter WAKE_CYCLES, default 2, retention-exit latency in cycles, >= 1.
REQ-007 SHALL have port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-008 SHALL have port rstn_i, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port req_i, input, 1, access request.
REQ-010 SHALL have port gnt_o, output, 1, request accepted this cycle.
REQ-011 SHALL have port addr_i, input, ADDR_WIDTH, word address: low log2(BANK_SIZE) bits select the row, the next log2(NUM_BANKS) bits select the bank.
REQ-012 SHALL have port we_i, input, 1, 1 = write, 0 = read.
REQ-013 SHALL have port be_i, input, DATA_WIDTH/8, byte enables, active-high.
REQ-014 SHALL have port wdata_i, input, DATA_WIDTH, write data.
REQ-015 SHALL have port rvalid_o, output, 1, response valid.
REQ-016 SHALL have port rdata_o, output, DATA_WIDTH, read data.
REQ-017 SHALL have port err_o, output, 1, out-of-range response, qualified by rvalid_o.
REQ-018 SHALL have port bank_sleep_o, output, NUM_BANKS, per-bank retention status.

Function
REQ-019 Handshake: a transfer occurs in any cycle where req_i and gnt_o are both 1; the master holds addr_i, we_i, be_i and wdata_i stable while req_i=1 and gnt_o=0.
REQ-020 gnt_o SHALL be req_i AND (address out of range OR addressed bank ACTIVE), combinational.
REQ-021 A granted read SHALL produce rvalid_o=1 with the row contents on rdata_o exactly one cycle later; back-to-back granted reads SHALL sustain one response per cycle.
REQ-022 A granted write SHALL update only bytes with be_i=1; rvalid_o=1 one cycle later with rdata_o all-zero.
REQ-023 Read-data mux select SHALL be the bank index registered at grant time, not the current addr_i.
REQ-024 An address >= NUM_BANKS*BANK_SIZE SHALL be granted without memory access; response one cycle later with err_o=1 and rdata_o=0.
REQ-025 rvalid_o and err_o SHALL be 0 in every cycle not following a grant; rdata_o SHALL hold its last value when rvalid_o=0.
REQ-026 Each bank SHALL have an FSM with states ACTIVE, SLEEP, WAKE; bank_sleep_o[b]=1 only in SLEEP.
REQ-027 ACTIVE: idle counter clears on a grant to that bank, otherwise increments; when it equals SLEEP_CYCLES-1 with no grant that cycle, the next state is SLEEP.
REQ-028 A grant in the same cycle the counter reaches SLEEP_CYCLES-1 SHALL win: counter clears and the bank stays ACTIVE.
REQ-029 SLEEP: req_i addressing the bank moves it to WAKE next cycle; the bank stays in WAKE for WAKE_CYCLES cycles, then goes ACTIVE with the idle counter at 0.
REQ-030 WAKE SHALL complete even if req_i drops; contents of every bank SHALL be preserved across SLEEP/WAKE.
REQ-031 Banks SHALL sleep and wake independently; an access to one bank SHALL NOT affect another bank's counter or state.

Reset
REQ-032 Asserting rstn_i SHALL immediately force rvalid_o=0, err_o=0, rdata_o=0, all FSMs to ACTIVE, idle counters to 0 and bank_sleep_o=0, including mid-WAKE and mid-response.
REQ-033 Memory contents SHALL NOT be reset; the first cycle after deassertion accepts requests.

Configuration
REQ-034 Macro BANKED_SP_RAM_SLEEP_EN defined: the sleep FSMs of REQ-026..031 SHALL be present.
REQ-035 Macro BANKED_SP_RAM_SLEEP_EN undefined: no FSMs or counters; every bank always ACTIVE; gnt_o=req_i; bank_sleep_o tied to 0; SLEEP_CYCLES and WAKE_CYCLES ignored.

Verification
REQ-036 Write 0xDEADBEEF to addr 0x2005 with be=0xF, then read 0x2005 -> gnt_o=1 both cycles, rvalid_o one cycle after each grant, read returns 0xDEADBEEF, err_o=0.
REQ-037 Pre-load 0x11223344, write 0xAABBCCDD with be=0x5 -> read returns 0x11BB33DD.
REQ-038 Reads to 0x0001 (bank 0) and 0x6001 (bank 3) in consecutive cycles -> rdata_o returns each bank's row in order, no bubble.
REQ-039 Read addr 0x8000 (NUM_BANKS=4, BANK_SIZE=8192) -> gnt_o=1 same cycle, rvalid_o=1, err_o=1, rdata_o=0 next cycle.
REQ-040 SLEEP_EN defined, last bank-1 access at cycle 10 -> bank_sleep_o[1]=1 from cycle 27; req at cycle 40 -> gnt_o=0 at 40..42, gnt_o=1 at 43, read data equals pre-sleep contents.
REQ-041 Assert rstn_i while bank 2 is in WAKE -> bank_sleep_o=0, rvalid_o=0; after release a request to bank 2 is granted in the same cycle.
